// File: rtl/mips_isa_pkg.sv
// Shared MIPS-subset ISA definitions: mnemonic codes, opcode/funct fields
// and the instruction loader's FSM state encoding. Also used by the decoder.
package mips_isa_pkg;

  // 4-bit mnemonic codes presented by the programming front-end
  localparam logic [3:0] MN_LW   = 4'd0;
  localparam logic [3:0] MN_SW   = 4'd1;
  localparam logic [3:0] MN_BEQ  = 4'd2;
  localparam logic [3:0] MN_ADDI = 4'd3;
  localparam logic [3:0] MN_J    = 4'd4;
  localparam logic [3:0] MN_ANDI = 4'd5;
  localparam logic [3:0] MN_ORI  = 4'd6;
  localparam logic [3:0] MN_ADD  = 4'd7;
  localparam logic [3:0] MN_SUB  = 4'd8;
  localparam logic [3:0] MN_AND  = 4'd9;
  localparam logic [3:0] MN_OR   = 4'd10;
  localparam logic [3:0] MN_SLT  = 4'd11;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // Loader FSM states; ST_PAD is only reachable in the NOP-padding build
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_PAD   = 3'd4
  } loader_state_e;

endpackage

// File: rtl/instr_word_encoder.sv
// Combinational MIPS-subset encoder: mnemonic plus fields in, 32-bit
// instruction word out. valid_o is low for mnemonic codes 12-15.
module instr_word_encoder
  import mips_isa_pkg::*;
(
  input  logic [3:0]  mnemonic_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic [31:0] word_o,
  output logic        valid_o
);

  // Select the instruction format and fixed opcode/funct for the mnemonic
  always_comb begin
    word_o  = 32'h0000_0000;
    valid_o = 1'b1;
    case (mnemonic_i)
      MN_LW:   word_o = {OP_LW,   rs_i, rt_i, imm_i};
      MN_SW:   word_o = {OP_SW,   rs_i, rt_i, imm_i};
      MN_BEQ:  word_o = {OP_BEQ,  rs_i, rt_i, imm_i};
      MN_ADDI: word_o = {OP_ADDI, rs_i, rt_i, imm_i};
      MN_ANDI: word_o = {OP_ANDI, rs_i, rt_i, imm_i};
      MN_ORI:  word_o = {OP_ORI,  rs_i, rt_i, imm_i};
      MN_J:    word_o = {OP_J, target_i};
      MN_ADD:  word_o = {OP_RTYPE, rs_i, rt_i, rd_i, 5'b00000, FN_ADD};
      MN_SUB:  word_o = {OP_RTYPE, rs_i, rt_i, rd_i, 5'b00000, FN_SUB};
      MN_AND:  word_o = {OP_RTYPE, rs_i, rt_i, rd_i, 5'b00000, FN_AND};
      MN_OR:   word_o = {OP_RTYPE, rs_i, rt_i, rd_i, 5'b00000, FN_OR};
      MN_SLT:  word_o = {OP_RTYPE, rs_i, rt_i, rd_i, 5'b00000, FN_SLT};
      default: valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_loader_encoder.sv
// Instruction loader: accepts one instruction per handshake, encodes it and
// writes it to consecutive instruction-memory words from BASE_ADDR.
// Optional macro INSTR_LOADER_NOP_PAD_EN: after the Last word, fill the rest
// of the address space with NOPs (32'h0) before reporting Done.
//
// Handshake: an instruction is taken on a rising edge where InValid and
// InReady are both high. InReady is high only in LOAD, and never depends on
// InValid. A taken valid instruction is written one cycle later (WRITE).
// StateDbg exposes the FSM state for observation only.
module instr_loader_encoder
  import mips_isa_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 0
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Start,
  input  logic              InValid,
  output logic              InReady,
  input  logic [3:0]        Mnemonic,
  input  logic [4:0]        Rs,
  input  logic [4:0]        Rt,
  input  logic [4:0]        Rd,
  input  logic [15:0]       Imm,
  input  logic [25:0]       Target,
  input  logic              Last,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [31:0]       MemWData,
  output logic [ADDR_W:0]   Count,
  output logic              Busy,
  output logic              Done,
  output logic              Error,
  output logic              Full,
  output logic [2:0]        StateDbg
);

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);

  loader_state_e     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [31:0]       word_q, word_d;
  logic              last_q, last_d;
  logic              error_q, error_d;
  logic              full_q, full_d;

  logic [31:0]       enc_word;
  logic              enc_valid;

  instr_word_encoder u_enc (
    .mnemonic_i (Mnemonic),
    .rs_i       (Rs),
    .rt_i       (Rt),
    .rd_i       (Rd),
    .imm_i      (Imm),
    .target_i   (Target),
    .word_o     (enc_word),
    .valid_o    (enc_valid)
  );

  // State and datapath registers; reset aborts any session immediately
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= BASE;
      count_q <= '0;
      word_q  <= '0;
      last_q  <= 1'b0;
      error_q <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      word_q  <= word_d;
      last_q  <= last_d;
      error_q <= error_d;
      full_q  <= full_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    count_d  = count_q;
    word_d   = word_q;
    last_d   = last_q;
    error_d  = error_q;
    full_d   = full_q;
    InReady  = 1'b0;
    MemWe    = 1'b0;
    MemAddr  = '0;
    MemWData = '0;
    Busy     = 1'b0;
    Done     = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        Done = (state_q == ST_DONE);
        if (Start) begin
          state_d = ST_LOAD;
          addr_d  = BASE;
          count_d = '0;
          error_d = 1'b0;
          full_d  = 1'b0;
        end
      end
      ST_LOAD: begin
        Busy    = 1'b1;
        InReady = 1'b1;
        if (InValid) begin
          if (enc_valid) begin
            word_d  = enc_word;
            last_d  = Last;
            state_d = ST_WRITE;
          end else begin
            // Bad mnemonic: flag it, write nothing, keep accepting
            error_d = 1'b1;
            if (Last) state_d = ST_DONE;
          end
        end
      end
      ST_WRITE: begin
        Busy     = 1'b1;
        MemWe    = 1'b1;
        MemAddr  = addr_q;
        MemWData = word_q;
        addr_d   = addr_q + ADDR_ONE;
        count_d  = count_q + CNT_ONE;
        if (last_q) begin
`ifdef INSTR_LOADER_NOP_PAD_EN
          // Nothing left to pad when the last word hit the top address
          state_d = (addr_q == LAST_ADDR) ? ST_DONE : ST_PAD;
`else
          state_d = ST_DONE;
`endif
        end else if (addr_q == LAST_ADDR) begin
          full_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_LOAD;
        end
      end
`ifdef INSTR_LOADER_NOP_PAD_EN
      ST_PAD: begin
        Busy     = 1'b1;
        MemWe    = 1'b1;
        MemAddr  = addr_q;
        MemWData = 32'h0000_0000;
        addr_d   = addr_q + ADDR_ONE;
        count_d  = count_q + CNT_ONE;
        if (addr_q == LAST_ADDR) state_d = ST_DONE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  assign Count    = count_q;
  assign Error    = error_q;
  assign Full     = full_q;
  assign StateDbg = state_q;

endmodule

// File: tb/tb_instr_loader_encoder.sv
// Self-checking bench for instr_loader_encoder. Directed instructions with
// hand-encoded words; expected writes go to a queue and a monitor compares
// every MemWe cycle against it. Built with INSTR_LOADER_NOP_PAD_EN it runs
// the padding scenario at ADDR_W=3, otherwise the base scenarios at ADDR_W=6.
module tb_instr_loader_encoder;
  import mips_isa_pkg::*;

`ifdef INSTR_LOADER_NOP_PAD_EN
  localparam int AW = 3;
`else
  localparam int AW = 6;
`endif

  // ---------------- clock / reset / signals ----------------
  logic          Clk = 1'b0;
  logic          Rst_n = 1'b0;
  logic          Start = 1'b0;
  logic          InValid = 1'b0;
  logic          InReady;
  logic [3:0]    Mnemonic = '0;
  logic [4:0]    Rs = '0, Rt = '0, Rd = '0;
  logic [15:0]   Imm = '0;
  logic [25:0]   Target = '0;
  logic          Last = 1'b0;
  logic          MemWe;
  logic [AW-1:0] MemAddr;
  logic [31:0]   MemWData;
  logic [AW:0]   Count;
  logic          Busy, Done, Error, Full;
  logic [2:0]    StateDbg;

  always #5 Clk = ~Clk;

  instr_loader_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .InValid(InValid),
    .InReady(InReady), .Mnemonic(Mnemonic), .Rs(Rs), .Rt(Rt), .Rd(Rd),
    .Imm(Imm), .Target(Target), .Last(Last), .MemWe(MemWe),
    .MemAddr(MemAddr), .MemWData(MemWData), .Count(Count), .Busy(Busy),
    .Done(Done), .Error(Error), .Full(Full), .StateDbg(StateDbg)
  );

  // ---------------- scoreboard ----------------
  logic [AW+31:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [AW-1:0] addr, input logic [31:0] word);
    exp_q.push_back({addr, word});
  endtask

  // Monitor: every write strobe must match the oldest expected write
  always @(negedge Clk) begin
    logic [AW+31:0] e;
    if (Rst_n === 1'b1 && MemWe !== 1'b0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: addr %0d data 0x%08h with none expected",
                 MemAddr, MemWData);
      end else begin
        e = exp_q.pop_front();
        check("mem_write", 64'({MemAddr, MemWData}), 64'(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_session();
    @(negedge Clk);
    Start = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0;
  endtask

  // Present one instruction and hold it until taken; returns 1 ns after the
  // accepting edge.
  task automatic send(input logic [3:0] mn, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd,
                      input logic [15:0] imm, input logic [25:0] tgt,
                      input logic last);
    int k;
    @(negedge Clk);
    Mnemonic = mn; Rs = rs; Rt = rt; Rd = rd; Imm = imm; Target = tgt;
    Last = last;
    InValid = 1'b1;
    k = 0;
    while (InReady !== 1'b1 && k < 50) begin
      @(negedge Clk);
      k++;
    end
    if (InReady !== 1'b1) check("inready_timeout", 64'(InReady), 64'd1);
    @(posedge Clk);
    #1;
    InValid = 1'b0;
    Last = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (Done !== 1'b1 && k < 300) begin
      @(negedge Clk);
      k++;
    end
    if (Done !== 1'b1) check("done_timeout", 64'(Done), 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge Clk);
    // Reset state
    check("rst_inready", 64'(InReady), 64'd0);
    check("rst_memwe",   64'(MemWe),   64'd0);
    check("rst_count",   64'(Count),   64'd0);
    check("rst_busy",    64'(Busy),    64'd0);
    check("rst_done",    64'(Done),    64'd0);
    check("rst_state",   64'(StateDbg), 64'(ST_IDLE));
    Rst_n = 1'b1;

`ifdef INSTR_LOADER_NOP_PAD_EN
    // ORI Rs=1 Rt=2 Imm=0x1234 with Last, then NOPs at 1..7
    start_session();
    push_exp(3'd0, 32'h3422_1234);
    for (int a = 1; a < 8; a++) push_exp(AW'(a), 32'h0000_0000);
    send(MN_ORI, 5'd1, 5'd2, 5'd0, 16'h1234, 26'd0, 1'b1);
    wait_done();
    check("pad_count", 64'(Count), 64'd8);
    check("pad_done",  64'(Done),  64'd1);
    check("pad_full",  64'(Full),  64'd0);
    check("pad_busy",  64'(Busy),  64'd0);
`else
    // T1: ADD Rd=3 Rs=1 Rt=2, Last; write one cycle after the handshake
    start_session();
    check("load_inready", 64'(InReady), 64'd1);
    push_exp(6'd0, 32'h0022_1820);
    send(MN_ADD, 5'd1, 5'd2, 5'd3, 16'h0, 26'd0, 1'b1);
    @(negedge Clk);
    check("t1_latency_memwe", 64'(MemWe), 64'd1);
    wait_done();
    check("t1_count", 64'(Count), 64'd1);
    check("t1_done",  64'(Done),  64'd1);
    check("t1_error", 64'(Error), 64'd0);

    // T2: LW Rt=8 Rs=29 Imm=4, then J 0x10 with Last
    start_session();
    check("t2_done_cleared", 64'(Done), 64'd0);
    push_exp(6'd0, 32'h8FA8_0004);
    push_exp(6'd1, 32'h0800_0010);
    send(MN_LW, 5'd29, 5'd8, 5'd0, 16'h0004, 26'd0, 1'b0);
    send(MN_J, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, 1'b1);
    wait_done();
    check("t2_count", 64'(Count), 64'd2);

    // T3: BEQ, invalid mnemonic 13 (no write), SUB with Last
    start_session();
    push_exp(6'd0, 32'h1022_FFFF);
    push_exp(6'd1, 32'h0021_0822);
    send(MN_BEQ, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'd0, 1'b0);
    send(4'd13, 5'd7, 5'd7, 5'd7, 16'h1111, 26'd0, 1'b0);
    send(MN_SUB, 5'd1, 5'd1, 5'd1, 16'h0, 26'd0, 1'b1);
    wait_done();
    check("t3_error", 64'(Error), 64'd1);
    check("t3_count", 64'(Count), 64'd2);

    // T4: Start during WRITE/LOAD ignored; Error cleared by new session
    start_session();
    check("t4_error_cleared", 64'(Error), 64'd0);
    push_exp(6'd0, 32'h3064_00FF);
    send(MN_ANDI, 5'd3, 5'd4, 5'd0, 16'h00FF, 26'd0, 1'b0);
    Start = 1'b1;
    repeat (2) @(posedge Clk);
    #1 Start = 1'b0;
    @(negedge Clk);
    check("t4_state_load", 64'(StateDbg), 64'(ST_LOAD));
    push_exp(6'd1, 32'h00C7_2825);
    send(MN_OR, 5'd6, 5'd7, 5'd5, 16'h0, 26'd0, 1'b1);
    wait_done();
    check("t4_count", 64'(Count), 64'd2);

    // T5: 64 ADDI without Last fill the space, then Full
    start_session();
    for (int i = 0; i < 64; i++) begin
      push_exp(AW'(i), 32'h2001_0000 | 32'(i));
      send(MN_ADDI, 5'd0, 5'd1, 5'd0, 16'(i), 26'd0, 1'b0);
    end
    wait_done();
    check("t5_full",   64'(Full),    64'd1);
    check("t5_done",   64'(Done),    64'd1);
    check("t5_count",  64'(Count),   64'd64);
    check("t5_inready", 64'(InReady), 64'd0);
    repeat (3) @(negedge Clk);

    // T6: reset on the cycle after a handshake suppresses the write
    start_session();
    @(negedge Clk);
    Mnemonic = MN_ADDI; Rs = 5'd2; Rt = 5'd3; Imm = 16'h0042; InValid = 1'b1;
    @(posedge Clk);
    #1 Rst_n = 1'b0;
    InValid = 1'b0;
    @(negedge Clk);
    check("t6_memwe",   64'(MemWe),    64'd0);
    check("t6_addr",    64'(MemAddr),  64'd0);
    check("t6_wdata",   64'(MemWData), 64'd0);
    check("t6_count",   64'(Count),    64'd0);
    check("t6_busy",    64'(Busy),     64'd0);
    check("t6_done",    64'(Done),     64'd0);
    check("t6_error",   64'(Error),    64'd0);
    check("t6_full",    64'(Full),     64'd0);
    check("t6_inready", 64'(InReady),  64'd0);
    check("t6_state",   64'(StateDbg), 64'(ST_IDLE));
    @(negedge Clk);
    Rst_n = 1'b1;
    repeat (3) @(negedge Clk);
    check("t6_idle_hold", 64'(StateDbg), 64'(ST_IDLE));
`endif

    repeat (4) @(negedge Clk);
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
